// File: rtl/fmlgen.sv
// Purpose : CSR-controlled FML traffic generator; issues 4-beat 64-bit bursts and checks read data.
// Latency : burst request one cycle after start; beats begin the cycle after fml_ack; csr_do one cycle after access.
// Backpres: fml_stb holds until fml_ack; beats are never stalled once a burst is accepted.
// Ports   : sys_clk/sys_rst_n clock and async active-low reset; csr_a/csr_we/csr_di/csr_do register access;
//           fml_adr/fml_stb/fml_we/fml_ack burst handshake; fml_sel/fml_do write beats; fml_di read beats.
module fmlgen #(
    parameter logic [3:0] csr_addr  = 4'h0,
    parameter int          fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [13:0]          csr_a,
    input  logic                 csr_we,
    input  logic [31:0]          csr_di,
    output logic [31:0]          csr_do,
    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    output logic                 fml_we,
    input  logic                 fml_ack,
    output logic [7:0]           fml_sel,
    output logic [63:0]          fml_do,
    input  logic [63:0]          fml_di
);
    // burst-granular (32-byte) address width
    localparam int BW = fml_depth - 5;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BEAT} state_t;

    state_t              r_state;
    logic [1:0]          r_beat;
    logic                r_we;
    logic                r_abort;
    logic [31:0]         r_base;
    logic [31:0]         r_count;
    logic [31:0]         r_done;
    logic [31:0]         r_seed;
    logic [31:0]         r_errs;
    logic [31:0]         r_cycles;
    logic [31:0]         r_csr_do;
    logic [fml_depth-1:0] r_adr;
    logic                r_stb;
    logic [7:0]          r_sel;
    logic [63:0]         r_do;

    logic        w_sel;
    logic        w_wr;
    logic        w_busy;
    logic        w_ctrl_wr;
    logic        w_abort_req;
    logic [31:0] w_word;
    logic [31:0] w_word_nxt;
    logic [63:0] w_pat;
    logic [31:0] w_done_inc;
    logic [BW-1:0] w_blk_nxt;
    logic        w_unused;

    assign w_sel       = (csr_a[13:10] == csr_addr);
    assign w_wr        = w_sel & csr_we;
    assign w_busy      = (r_state != S_IDLE);
    assign w_ctrl_wr   = w_wr & (csr_a[2:0] == 3'd0);
    assign w_abort_req = w_busy & w_ctrl_wr & ~csr_di[0];

    // r_beat sits at 0 outside BEAT, so w_word is also the first word of the next burst while in REQ
    assign w_word     = r_seed + {r_done[29:0], 2'b00} + {30'd0, r_beat};
    assign w_word_nxt = w_word + 32'd1;
    assign w_pat      = {~w_word, w_word};
    assign w_done_inc = r_done + 32'd1;
    assign w_blk_nxt  = r_base[fml_depth-1:5] + w_done_inc[BW-1:0];

    assign w_unused = &{1'b0, csr_a[9:3]};

    assign csr_do  = r_csr_do;
    assign fml_adr = r_adr;
    assign fml_stb = r_stb;
    assign fml_we  = r_we;
    assign fml_sel = r_sel;
    assign fml_do  = r_do;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= S_IDLE;
            r_beat   <= 2'd0;
            r_we     <= 1'b0;
            r_abort  <= 1'b0;
            r_base   <= 32'd0;
            r_count  <= 32'd0;
            r_done   <= 32'd0;
            r_seed   <= 32'd0;
            r_errs   <= 32'd0;
            r_cycles <= 32'd0;
            r_csr_do <= 32'd0;
            r_adr    <= '0;
            r_stb    <= 1'b0;
            r_sel    <= 8'd0;
            r_do     <= 64'd0;
        end else begin
            // register read data reflects the values before any write on this edge
            if (!w_sel) begin
                r_csr_do <= 32'd0;
            end else begin
                case (csr_a[2:0])
                    3'd0:    r_csr_do <= {30'd0, r_we, w_busy};
                    3'd1:    r_csr_do <= r_base;
                    3'd2:    r_csr_do <= r_count;
                    3'd3:    r_csr_do <= r_done;
                    3'd4:    r_csr_do <= r_seed;
                    3'd5:    r_csr_do <= r_errs;
                    3'd6:    r_csr_do <= r_cycles;
                    default: r_csr_do <= 32'd0;
                endcase
            end

            if (w_busy) begin
                r_cycles <= r_cycles + 32'd1;
            end

            if (w_wr && !w_busy) begin
                case (csr_a[2:0])
                    3'd1:    r_base  <= csr_di;
                    3'd2:    r_count <= csr_di;
                    3'd4:    r_seed  <= csr_di;
                    default: ;
                endcase
            end

            if (w_abort_req) begin
                r_abort <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_ctrl_wr && csr_di[0]) begin
                        r_done   <= 32'd0;
                        r_errs   <= 32'd0;
                        r_cycles <= 32'd0;
                        if (r_count != 32'd0) begin
                            r_we    <= csr_di[1];
                            r_state <= S_REQ;
                            r_stb   <= 1'b1;
                            r_adr   <= {r_base[fml_depth-1:5], 5'b00000};
                        end
                    end
                end
                S_REQ: begin
                    if (fml_ack) begin
                        r_stb   <= 1'b0;
                        r_state <= S_BEAT;
                        r_beat  <= 2'd0;
                        if (r_we) begin
                            r_do  <= w_pat;
                            r_sel <= 8'hFF;
                        end
                    end
                end
                S_BEAT: begin
                    if (!r_we && (fml_di != w_pat) && (r_errs != 32'hFFFF_FFFF)) begin
                        r_errs <= r_errs + 32'd1;
                    end
                    r_beat <= r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        r_do   <= 64'd0;
                        r_sel  <= 8'd0;
                        r_done <= w_done_inc;
                        // an abort written on this very edge still stops before the next burst
                        if ((w_done_inc == r_count) || r_abort || w_abort_req) begin
                            r_state <= S_IDLE;
                            r_abort <= 1'b0;
                        end else begin
                            r_state <= S_REQ;
                            r_stb   <= 1'b1;
                            r_adr   <= {w_blk_nxt, 5'b00000};
                        end
                    end else if (r_we) begin
                        r_do <= {~w_word_nxt, w_word_nxt};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fmlgen.sv
// Purpose : self-checking bench for fmlgen with an emulated FML memory and a burst-level reference model.
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpres: ack delay per run is programmable; the bench always acks within the chosen delay.
module tb_fmlgen;
    logic        sys_clk;
    logic        sys_rst_n;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic [25:0] fml_adr;
    logic        fml_stb;
    logic        fml_we;
    logic        fml_ack;
    logic [7:0]  fml_sel;
    logic [63:0] fml_do;
    logic [63:0] fml_di;

    int n_vec = 0;
    int n_err = 0;

    fmlgen #(.csr_addr(4'h0), .fml_depth(26)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
        .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_ack(fml_ack),
        .fml_sel(fml_sel), .fml_do(fml_do), .fml_di(fml_di)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic [31:0] base;
        logic [31:0] count;
        logic [31:0] seed;
        bit          we;
        int          ack;
        logic [3:0]  err0;
        bit          abort;
        logic [31:0] exp_done;
        logic [31:0] exp_err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 32-byte block number advances by one per burst, wrapping in the 26-bit byte space
    function automatic logic [25:0] model_adr(input logic [31:0] base, input int k);
        longint blk;
        blk = ((longint'(base) / 32) + k) % 2097152;
        return 26'(blk * 32);
    endfunction

    function automatic logic [63:0] model_pat(input logic [31:0] seed, input int k, input int b);
        logic [31:0] w;
        w = seed + 32'(4 * k + b);
        return {~w, w};
    endfunction

    task automatic csr_wr(input logic [2:0] idx, input logic [31:0] d);
        csr_a  = {4'h0, 7'd0, idx};
        csr_di = d;
        csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input logic [3:0] bank, input logic [2:0] idx, output logic [31:0] d);
        csr_a  = {bank, 7'd0, idx};
        csr_we = 1'b0;
        @(negedge sys_clk);
        d = csr_do;
    endtask

    task automatic wait_stb(output bit seen);
        int w;
        w = 0;
        while (!fml_stb && w < 50) begin
            @(negedge sys_clk);
            w++;
        end
        seen = fml_stb;
    endtask

    task automatic run_case(input logic [31:0] base, input logic [31:0] cnt, input logic [31:0] seed,
                            input bit we, input int ack, input logic [3:0] emask [4], input bit abort,
                            input logic [31:0] exp_done, input logic [31:0] exp_err);
        logic [63:0] pat;
        logic [31:0] d;
        bit          seen;
        bit          extra;
        csr_wr(3'd1, base);
        csr_wr(3'd2, cnt);
        csr_wr(3'd4, seed);
        csr_wr(3'd0, {30'd0, we, 1'b1});
        for (int k = 0; k < int'(exp_done); k++) begin
            wait_stb(seen);
            check("stb_seen", 64'(seen), 64'd1);
            if (!seen) break;
            check("adr", 64'(fml_adr), 64'(model_adr(base, k)));
            check("we_out", 64'(fml_we), 64'(we));
            check("sel_in_req", 64'(fml_sel), 64'd0);
            for (int c = 1; c < ack; c++) begin
                @(negedge sys_clk);
                check("stb_hold", 64'(fml_stb), 64'd1);
            end
            fml_ack = 1'b1;
            @(negedge sys_clk);
            fml_ack = 1'b0;
            check("stb_drop", 64'(fml_stb), 64'd0);
            for (int b = 0; b < 4; b++) begin
                pat = model_pat(seed, k, b);
                if (we) begin
                    check("beat_do", fml_do, pat);
                    check("beat_sel", 64'(fml_sel), 64'hFF);
                end else begin
                    fml_di = emask[k][b] ? 64'd0 : pat;
                end
                // mid-burst CSR pokes: start/abort on ctrl, then a count change that must be ignored
                if (k == 0 && b == 0) begin
                    csr_a = 14'd0; csr_di = abort ? 32'd0 : 32'd1; csr_we = 1'b1;
                end else if (k == 0 && b == 2) begin
                    csr_a = 14'd2; csr_di = 32'd1; csr_we = 1'b1;
                end
                @(negedge sys_clk);
                csr_we = 1'b0;
                fml_di = 64'd0;
            end
            check("do_after", fml_do, 64'd0);
            check("sel_after", 64'(fml_sel), 64'd0);
        end
        extra = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (fml_stb) extra = 1'b1;
            @(negedge sys_clk);
        end
        check("no_extra_stb", 64'(extra), 64'd0);
        csr_rd(4'h0, 3'd0, d); check("r0_ctrl", 64'(d), 64'({we, 1'b0}));
        csr_rd(4'h0, 3'd1, d); check("r1_base", 64'(d), 64'(base));
        csr_rd(4'h0, 3'd2, d); check("r2_count", 64'(d), 64'(cnt));
        csr_rd(4'h0, 3'd3, d); check("r3_done", 64'(d), 64'(exp_done));
        csr_rd(4'h0, 3'd4, d); check("r4_seed", 64'(d), 64'(seed));
        csr_rd(4'h0, 3'd5, d); check("r5_errs", 64'(d), 64'(exp_err));
        csr_rd(4'h0, 3'd6, d); check("r6_cycles", 64'(d), 64'(exp_done * 32'(ack + 4)));
        csr_rd(4'h0, 3'd7, d); check("r7_zero", 64'(d), 64'd0);
    endtask

    initial begin
        vec_t        tbl [5];
        logic [3:0]  m [4];
        logic [31:0] d;
        logic [31:0] r_cnt;
        logic [31:0] e;
        bit          we_r;
        bit          seen;
        bit          extra;

        tbl[0] = '{32'h100,     32'd3 - 32'd1, 32'h0,        1'b1, 3, 4'b0000, 1'b0, 32'd2, 32'd0};
        tbl[1] = '{32'h40,      32'd1, 32'd5,        1'b0, 1, 4'b0100, 1'b0, 32'd1, 32'd1};
        tbl[2] = '{32'h200,     32'd3, 32'd7,        1'b1, 2, 4'b0000, 1'b1, 32'd1, 32'd0};
        tbl[3] = '{32'h3FFFFE0, 32'd2, 32'h12345678, 1'b1, 1, 4'b0000, 1'b0, 32'd2, 32'd0};
        tbl[4] = '{32'h1000,    32'd2, 32'hFFFFFFFE, 1'b0, 2, 4'b1001, 1'b0, 32'd2, 32'd2};

        sys_rst_n = 1'b0;
        csr_a = 14'd0; csr_we = 1'b0; csr_di = 32'd0;
        fml_ack = 1'b0; fml_di = 64'd0;
        repeat (3) @(negedge sys_clk);
        check("rst_stb", 64'(fml_stb), 64'd0);
        check("rst_sel", 64'(fml_sel), 64'd0);
        check("rst_do", fml_do, 64'd0);
        check("rst_adr", 64'(fml_adr), 64'd0);
        check("rst_csr_do", 64'(csr_do), 64'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        for (int r = 0; r < 8; r++) begin
            csr_rd(4'h0, 3'(r), d);
            check("rst_reg", 64'(d), 64'd0);
        end

        // directed vectors
        for (int i = 0; i < 5; i++) begin
            m[0] = tbl[i].err0; m[1] = 4'd0; m[2] = 4'd0; m[3] = 4'd0;
            run_case(tbl[i].base, tbl[i].count, tbl[i].seed, tbl[i].we, tbl[i].ack, m,
                     tbl[i].abort, tbl[i].exp_done, tbl[i].exp_err);
        end

        // start with zero count: counts from the previous read run must clear, nothing issued
        csr_wr(3'd2, 32'd0);
        csr_wr(3'd0, 32'd1);
        extra = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (fml_stb) extra = 1'b1;
            @(negedge sys_clk);
        end
        check("cnt0_no_stb", 64'(extra), 64'd0);
        csr_rd(4'h0, 3'd0, d); check("cnt0_busy", 64'(d[0]), 64'd0);
        csr_rd(4'h0, 3'd3, d); check("cnt0_done", 64'(d), 64'd0);
        csr_rd(4'h0, 3'd5, d); check("cnt0_errs", 64'(d), 64'd0);
        csr_rd(4'h0, 3'd6, d); check("cnt0_cycles", 64'(d), 64'd0);
        csr_rd(4'h5, 3'd1, d); check("unsel_bank", 64'(d), 64'd0);

        // randomized runs against the burst-level model
        for (int i = 0; i < 8; i++) begin
            r_cnt = 32'($urandom_range(1, 3));
            we_r  = 1'($urandom_range(0, 1));
            e = 32'd0;
            for (int k = 0; k < 4; k++) begin
                m[k] = we_r ? 4'd0 : 4'($urandom_range(0, 15));
                if (k < int'(r_cnt)) e += 32'($countones(m[k]));
            end
            run_case($urandom, r_cnt, $urandom, we_r, int'($urandom_range(1, 4)), m, 1'b0, r_cnt, e);
        end

        // reset while a request is pending without ack
        csr_wr(3'd1, 32'h800);
        csr_wr(3'd2, 32'd2);
        csr_wr(3'd4, 32'd9);
        csr_wr(3'd0, 32'd3);
        wait_stb(seen);
        check("pre_rst_stb", 64'(seen), 64'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_stb", 64'(fml_stb), 64'd0);
        check("async_we", 64'(fml_we), 64'd0);
        check("async_adr", 64'(fml_adr), 64'd0);
        check("async_csr_do", 64'(csr_do), 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        extra = 1'b0;
        for (int r = 0; r < 7; r++) begin
            csr_rd(4'h0, 3'(r), d);
            if (fml_stb) extra = 1'b1;
            check("post_rst_reg", 64'(d), 64'd0);
        end
        check("post_rst_idle", 64'(extra), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
